fifo_prog: RTL and testbench
============================

FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the storage depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter FWFT, default 0, SHALL select the read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 Parameter AF_THRESH, default DEPTH-4, SHALL set the almost_full threshold, legal range 1..DEPTH.
REQ-005 Parameter AE_THRESH, default 4, SHALL set the almost_empty threshold, legal range 0..DEPTH-1.
REQ-006 Parameter TYPE, default "distributed", SHALL be passed as the RAM style attribute of the storage array.
REQ-007 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-008 reset  input  1  SHALL be the reset: asynchronous and active-high.
REQ-009 flush  input  1  SHALL be a synchronous empty command.
REQ-010 s_write_req  input  1  SHALL be the push request.
REQ-011 s_write_data  input  DATA_WIDTH  SHALL be the push data.
REQ-012 s_write_ready  output  1  SHALL mean not full.
REQ-013 s_read_req  input  1  SHALL be the pop request.
REQ-014 s_read_data  output  DATA_WIDTH  SHALL be the pop data.
REQ-015 s_read_ready  output  1  SHALL mean at least one word is readable.
REQ-016 fifo_count  output  ADDR_WIDTH+1  SHALL give the occupancy, 0..DEPTH.
REQ-017 almost_full, almost_empty  output  1 each  SHALL be the threshold flags.
REQ-018 overflow, underflow  output  1 each  SHALL be sticky error flags.

Function
REQ-019 A write SHALL be accepted iff s_write_req && s_write_ready && !flush; a read SHALL be accepted iff s_read_req && s_read_ready && !flush.
REQ-020 A write into a full FIFO SHALL be rejected even when a read is accepted in the same cycle; a read from an empty FIFO SHALL be rejected even when a write is accepted in the same cycle.
REQ-021 fifo_count SHALL be incremented on write-only, decremented on read-only, and held on both or neither.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH with no extra logic.
REQ-023 FWFT=0: data of an accepted read SHALL appear on s_read_data on the following cycle and SHALL hold until the next accepted read.
REQ-024 FWFT=1: while s_read_ready=1, s_read_data SHALL present the head word; an accepted read SHALL advance to the next word at the next edge.
REQ-025 FWFT=1: a word written into an empty FIFO SHALL be presented, with s_read_ready=1, one cycle after write acceptance; fifo_count SHALL include the presented word.
REQ-026 s_write_ready, s_read_ready, almost_full (count >= AF_THRESH) and almost_empty (count <= AE_THRESH) SHALL be registered and SHALL reflect the count after the same edge.
REQ-027 overflow SHALL set on s_write_req while full; underflow SHALL set on s_read_req while !s_read_ready; both SHALL clear only on reset or flush.
REQ-028 flush SHALL zero the pointers, count and error flags and SHALL override concurrent requests; RAM contents SHALL be left unchanged.
REQ-029 The RAM SHALL not be written when a write is rejected.

Reset
REQ-030 When reset is asserted: count = 0; s_write_ready = 1; s_read_ready = 0; almost_empty = 1; almost_full, overflow, underflow = 0; s_read_data = 0.
REQ-031 Reset asserted mid-transfer SHALL discard all contents; the first accepted write after reset SHALL be the first word read.

Structure
REQ-032 Package fifo_pkg SHALL hold the FWFT mode encodings and the depth/count-width helper function.
REQ-033 Storage SHALL be a sub-module fifo_ram: simple dual-port, one write port and one read port, with the TYPE attribute; the fifo_prog top SHALL own control and the FWFT output stage.

Verification
REQ-034 DEPTH=16, FWFT=0: 16 writes of 0..15, then one further write -> s_write_ready=0 after the 16th write; overflow=1; fifo_count=16; 16 reads return 0..15 in order.
REQ-035 FWFT=1: write 0xA5 into the empty FIFO -> next cycle s_read_ready=1, s_read_data=0xA5 with no read request; a read pulse -> count=0 and s_read_ready=0.
REQ-036 Full FIFO, simultaneous read and write -> read accepted, write rejected, count=15; at count=0, simultaneous read and write -> write accepted, underflow=1, count=1.
REQ-037 AF_THRESH=12, AE_THRESH=4: count 11->12 -> almost_full rises on the same edge; count 5->4 -> almost_empty rises.
REQ-038 Reset asserted asynchronously at count=7 -> all outputs take their REQ-030 reset values with no clock edge; after release, write 0x1 then read -> 0x1 is returned.
REQ-039 flush together with a write at count=9 -> count=0; write ignored; overflow and underflow cleared.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the programmable FIFO: the read-mode encodings
// selected by the FWFT parameter, and helpers that turn an address width
// into a storage depth and an occupancy-counter width.
package fifo_pkg;

  // Read-mode encodings for the FWFT parameter
  typedef enum logic {
    FWFT_STANDARD     = 1'b0,
    FWFT_FALL_THROUGH = 1'b1
  } fwft_mode_e;

  // Number of words held by a RAM addressed with addr_width bits
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // The count must reach DEPTH itself, so it needs one bit more than the pointers
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// Simple dual-port storage for fifo_prog: one synchronous write port and one
// asynchronous read port. The array carries the RAM style attribute given by
// TYPE. Contents have no reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter     TYPE       = "distributed"
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  (* ram_style = TYPE *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Single write port; no reset so the array maps onto RAM primitives
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// fifo_prog
// Synchronous FIFO with a selectable read mode, programmable almost-full /
// almost-empty thresholds and sticky overflow / underflow flags.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   flush                   - synchronous empty command, overrides requests
//   s_write_req/data/ready  - push side; ready means not full
//   s_read_req/data/ready   - pop side; ready means a word is readable
//   fifo_count              - occupancy 0..DEPTH
//   almost_full/empty       - threshold flags (count >= AF, count <= AE)
//   overflow/underflow      - sticky error flags, cleared by reset or flush
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 4,
  parameter     TYPE       = "distributed"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_write_req,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  output logic                  s_write_ready,
  input  logic                  s_read_req,
  output logic [DATA_WIDTH-1:0] s_read_data,
  output logic                  s_read_ready,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int               CW       = count_width(ADDR_WIDTH);
  localparam int               DEPTH    = fifo_depth(ADDR_WIDTH);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    AF_T     = CW'(AF_THRESH);
  localparam logic [CW-1:0]    AE_T     = CW'(AE_THRESH);
  localparam bit               IS_FWFT  = (FWFT == int'(FWFT_FALL_THROUGH));

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_next, rd_ptr_next;
  logic [CW-1:0]         count_next;
  logic                  wr_accept, rd_accept;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] head_data;

  // The registered ready flags already encode full/empty, so a write to a
  // full FIFO or a read from an empty one is refused even if the other side
  // is moving in the same cycle.
  assign wr_accept = s_write_req && s_write_ready && !flush;
  assign rd_accept = s_read_req  && s_read_ready  && !flush;

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = fifo_count;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_accept) wr_ptr_next = wr_ptr + 1'b1;
      if (rd_accept) rd_ptr_next = rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count_next = fifo_count + 1'b1;
        2'b01:   count_next = fifo_count - 1'b1;
        default: count_next = fifo_count;
      endcase
    end
  end

  // Fall-through mode preloads the word that will be at the head after this
  // edge; standard mode reads the current head when a read is accepted.
  assign ram_raddr = IS_FWFT ? rd_ptr_next : rd_ptr;

  // A word being written into the slot that becomes the head this edge is
  // not yet in the RAM, so forward it straight from the write port.
  assign head_data = (wr_accept && (wr_ptr == rd_ptr_next)) ? s_write_data : ram_rdata;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TYPE       (TYPE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (s_write_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Pointers, count, status flags and the output data register. All status
  // flags are computed from count_next so they agree with fifo_count after
  // the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      s_write_ready <= 1'b1;
      s_read_ready  <= 1'b0;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      s_read_data   <= '0;
    end else begin
      wr_ptr        <= wr_ptr_next;
      rd_ptr        <= rd_ptr_next;
      fifo_count    <= count_next;
      s_write_ready <= (count_next != FULL_CNT);
      s_read_ready  <= (count_next != '0);
      almost_full   <= (count_next >= AF_T);
      almost_empty  <= (count_next <= AE_T);

      if (flush) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (s_write_req && !s_write_ready) overflow  <= 1'b1;
        if (s_read_req  && !s_read_ready)  underflow <= 1'b1;
      end

      if (IS_FWFT) begin
        if (!flush && (count_next != '0)) s_read_data <= head_data;
      end else begin
        if (rd_accept) s_read_data <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog
// Drives one standard-read and one fall-through instance of fifo_prog with
// identical stimulus and compares both against a queue-based reference model.
module tb_fifo_prog;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          rd_req;

  logic          std_wr_ready, std_rd_ready, std_af, std_ae, std_ovf, std_unf;
  logic [DW-1:0] std_rdata;
  logic [AW:0]   std_count;
  logic          ff_wr_ready, ff_rd_ready, ff_af, ff_ae, ff_ovf, ff_unf;
  logic [DW-1:0] ff_rdata;
  logic [AW:0]   ff_count;

  // Reference model state
  logic [DW-1:0] sb[$];
  int            m_count;
  logic [DW-1:0] m_last;
  logic          m_ovf, m_unf;
  int            total;
  int            bad;

  fifo_prog #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (0),
    .AF_THRESH (AF), .AE_THRESH (AE), .TYPE ("distributed")
  ) u_std (
    .clk (clk), .reset (reset), .flush (flush),
    .s_write_req (wr_req), .s_write_data (wr_data), .s_write_ready (std_wr_ready),
    .s_read_req (rd_req), .s_read_data (std_rdata), .s_read_ready (std_rd_ready),
    .fifo_count (std_count), .almost_full (std_af), .almost_empty (std_ae),
    .overflow (std_ovf), .underflow (std_unf)
  );

  fifo_prog #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (1),
    .AF_THRESH (AF), .AE_THRESH (AE), .TYPE ("distributed")
  ) u_ff (
    .clk (clk), .reset (reset), .flush (flush),
    .s_write_req (wr_req), .s_write_data (wr_data), .s_write_ready (ff_wr_ready),
    .s_read_req (rd_req), .s_read_data (ff_rdata), .s_read_ready (ff_rd_ready),
    .fifo_count (ff_count), .almost_full (ff_af), .almost_empty (ff_ae),
    .overflow (ff_ovf), .underflow (ff_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and counts and reports it if it fails
  task automatic check_output(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_last  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Compare both instances with the model: count, flags, and data
  task automatic check_all(input string tag);
    logic [5:0] exp_flags;
    exp_flags = {(m_count != DEPTH), (m_count != 0), (m_count >= AF),
                 (m_count <= AE), m_ovf, m_unf};
    check_output({tag, "/std.count"}, DW'(std_count), DW'(m_count));
    check_output({tag, "/std.flags"},
                 DW'({std_wr_ready, std_rd_ready, std_af, std_ae, std_ovf, std_unf}),
                 DW'(exp_flags));
    check_output({tag, "/std.rdata"}, std_rdata, m_last);
    check_output({tag, "/ff.count"}, DW'(ff_count), DW'(m_count));
    check_output({tag, "/ff.flags"},
                 DW'({ff_wr_ready, ff_rd_ready, ff_af, ff_ae, ff_ovf, ff_unf}),
                 DW'(exp_flags));
    if (m_count != 0) check_output({tag, "/ff.rdata"}, ff_rdata, sb[0]);
  endtask

  // Drive one cycle of requests, advance the model, then check after the edge
  task automatic apply_stimulus(input string tag, input logic w, input logic [DW-1:0] d,
                                input logic r, input logic f);
    logic wa, ra;
    wr_req  = w;
    wr_data = d;
    rd_req  = r;
    flush   = f;
    wa = w && (m_count != DEPTH) && !f;
    ra = r && (m_count != 0) && !f;
    if (f) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
      sb.delete();
      m_count = 0;
    end else begin
      if (w && (m_count == DEPTH)) m_ovf = 1'b1;
      if (r && (m_count == 0))     m_unf = 1'b1;
      if (ra) m_last = sb.pop_front();
      if (wa) sb.push_back(d);
      m_count = m_count + int'(wa) - int'(ra);
    end
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    flush  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic          w, r, f;
    logic [DW-1:0] d;
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    flush   = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = '0;
    model_reset();

    // Power-on reset values
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check_output("reset/ff.rdata", ff_rdata, '0);
    reset = 1'b0;

    // Fall-through presentation of a single word, then a read pulse
    apply_stimulus("fwft_write", 1'b1, 64'hA5, 1'b0, 1'b0);
    check_output("fwft_present", DW'(ff_rd_ready), DW'(1'b1));
    apply_stimulus("fwft_idle", 1'b0, '0, 1'b0, 1'b0);
    apply_stimulus("fwft_read", 1'b0, '0, 1'b1, 1'b0);

    // Fill with 0..15, then one more write into the full FIFO
    for (int i = 0; i < DEPTH; i++) apply_stimulus("fill", 1'b1, DW'(i), 1'b0, 1'b0);
    apply_stimulus("overflow", 1'b1, 64'h99, 1'b0, 1'b0);

    // Full: read and write together -> only the read is accepted
    apply_stimulus("full_rw", 1'b1, 64'h77, 1'b1, 1'b0);

    // Drain the remaining 1..15 through the almost_empty threshold
    for (int i = 1; i < DEPTH; i++) apply_stimulus("drain", 1'b0, '0, 1'b1, 1'b0);

    // Empty: read and write together -> only the write is accepted
    apply_stimulus("empty_rw", 1'b1, 64'h55, 1'b1, 1'b0);

    // Climb to count 9, then flush with a concurrent write
    for (int i = 0; i < 8; i++) apply_stimulus("to9", 1'b1, DW'(64'h100 + i), 1'b0, 1'b0);
    apply_stimulus("flush_w", 1'b1, 64'hDEAD, 1'b0, 1'b1);
    apply_stimulus("after_flush", 1'b1, 64'h1234, 1'b0, 1'b0);
    apply_stimulus("after_flush_rd", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset at count 7, away from any clock edge
    for (int i = 0; i < 7; i++) apply_stimulus("to7", 1'b1, DW'(64'h200 + i), 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    check_output("async_reset/ff.rdata", ff_rdata, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus("post_reset_w", 1'b1, 64'h1, 1'b0, 1'b0);
    apply_stimulus("post_reset_r", 1'b0, '0, 1'b1, 1'b0);

    // Mixed traffic: write-heavy phase then read-heavy phase, rare flushes
    for (int i = 0; i < 300; i++) begin
      if (i < 150) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      f = ($urandom_range(0, 63) == 0);
      d = {$urandom, $urandom};
      apply_stimulus("random", w, d, r, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
